// File: rtl/aes_pkg.sv
// Shared AES feeder definitions: block geometry, feeder FSM states and the key/plaintext pair payload.
package aes_pkg;

    localparam int unsigned AES_BLOCK_BITS    = 128;
    localparam int unsigned AES_BYTES         = 16;
    localparam int unsigned AES_BYTE_BITS     = 8;
    localparam int unsigned AES_BYTE_IDX_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        WAIT = 2'd2
    } feeder_state_e;

    typedef struct packed {
        logic [AES_BLOCK_BITS-1:0] key;
        logic [AES_BLOCK_BITS-1:0] data;
    } aes_pair_t;

endpackage

// File: rtl/aes_byte_shifter.sv
// 128-bit parallel-load register that presents its top byte and shifts left one byte per shift strobe.
module aes_byte_shifter
    import aes_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      shift,
    input  logic [AES_BLOCK_BITS-1:0] din,
    output logic [AES_BYTE_BITS-1:0]  byte_out
);

    logic [AES_BLOCK_BITS-1:0] sh_q;

    // Zeros fill from the bottom, so the word is empty once all 16 bytes have gone out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else if (load) begin
            sh_q <= din;
        end else if (shift) begin
            sh_q <= {sh_q[AES_BLOCK_BITS-AES_BYTE_BITS-1:0], {AES_BYTE_BITS{1'b0}}};
        end
    end

    assign byte_out = sh_q[AES_BLOCK_BITS-1 -: AES_BYTE_BITS];

endmodule

// File: rtl/aes_enc_feeder.sv
// Accepts a key/plaintext pair, streams it MSB-first byte-serially into an AES core,
// then waits for core_ready with a bounded timeout.
module aes_enc_feeder
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AES_BLOCK_BITS-1:0] in_key,
    input  logic [AES_BLOCK_BITS-1:0] in_data,
    output logic [AES_BYTE_BITS-1:0]  key_byte,
    output logic [AES_BYTE_BITS-1:0]  state_byte,
    output logic                      enable,
    input  logic                      core_ready,
    output logic                      done,
    output logic                      timeout,
    output logic                      busy
);

    localparam int unsigned WAIT_CNT_BITS = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [WAIT_CNT_BITS-1:0] WAIT_LIMIT = WAIT_CNT_BITS'(TIMEOUT_CYCLES);
    localparam logic [AES_BYTE_IDX_BITS-1:0] LAST_BYTE = AES_BYTE_IDX_BITS'(AES_BYTES - 1);

    feeder_state_e                state_q, state_d;
    logic [AES_BYTE_IDX_BITS-1:0] byte_cnt_q, byte_cnt_d;
    logic [WAIT_CNT_BITS-1:0]     wait_cnt_q, wait_cnt_d, wait_cnt_inc;
    logic                         enable_d, done_d, timeout_d;
    logic                         load_c, shift_c, accept_c;
    aes_pair_t                    pair_c;

    assign in_ready     = (state_q == IDLE) && !rst;
    assign accept_c     = in_valid && in_ready;
    assign busy         = (state_q == FEED) || (state_q == WAIT);
    assign wait_cnt_inc = wait_cnt_q + WAIT_CNT_BITS'(1);
    assign pair_c       = '{key: in_key, data: in_data};

    // State and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            wait_cnt_q <= '0;
            enable     <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            enable     <= enable_d;
            done       <= done_d;
            timeout    <= timeout_d;
        end
    end

    // Next-state and control decode; done/timeout are single-cycle pulses by default.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wait_cnt_d = wait_cnt_q;
        enable_d   = enable;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        load_c     = 1'b0;
        shift_c    = 1'b0;

        case (state_q)
            IDLE: begin
                enable_d = 1'b0;
                if (accept_c) begin
                    state_d    = FEED;
                    byte_cnt_d = '0;
                    load_c     = 1'b1;
                    enable_d   = 1'b1;
                end
            end

            FEED: begin
                shift_c = 1'b1;
                if (byte_cnt_q == LAST_BYTE) begin
                    state_d    = WAIT;
                    wait_cnt_d = '0;
                end else begin
                    byte_cnt_d = byte_cnt_q + AES_BYTE_IDX_BITS'(1);
                end
            end

            WAIT: begin
                wait_cnt_d = wait_cnt_inc;
                // core_ready takes priority over an expiring timeout on the same edge.
                if (core_ready) begin
                    state_d    = IDLE;
                    enable_d   = 1'b0;
                    done_d     = 1'b1;
                    wait_cnt_d = '0;
                end else if (wait_cnt_inc >= WAIT_LIMIT) begin
                    state_d    = IDLE;
                    enable_d   = 1'b0;
                    timeout_d  = 1'b1;
                    wait_cnt_d = '0;
                end
            end

            default: begin
                state_d  = IDLE;
                enable_d = 1'b0;
            end
        endcase
    end

    aes_byte_shifter u_key_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .shift    (shift_c),
        .din      (pair_c.key),
        .byte_out (key_byte)
    );

    aes_byte_shifter u_data_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .shift    (shift_c),
        .din      (pair_c.data),
        .byte_out (state_byte)
    );

endmodule

// File: tb/tb_aes_enc_feeder.sv
// Scoreboard bench for aes_enc_feeder: the driver predicts every output cycle from a byte-stream model,
// a negedge monitor pops and compares whenever the feeder shows activity.
module tb_aes_enc_feeder;

    localparam int T = 8;

    typedef struct packed {
        logic       done;
        logic       timeout;
        logic       enable;
        logic       busy;
        logic       in_ready;
        logic [7:0] kb;
        logic [7:0] sb;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_key = '0;
    logic [127:0] in_data = '0;
    logic [7:0]   key_byte;
    logic [7:0]   state_byte;
    logic         enable;
    logic         core_ready = 1'b0;
    logic         done;
    logic         timeout;
    logic         busy;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    aes_enc_feeder #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_key     (in_key),
        .in_data    (in_data),
        .key_byte   (key_byte),
        .state_byte (state_byte),
        .enable     (enable),
        .core_ready (core_ready),
        .done       (done),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [127:0] w, input int k);
        logic [127:0] s;
        s = w >> (8 * (15 - k));
        return s[7:0];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{done: done, timeout: timeout, enable: enable, busy: busy,
              in_ready: in_ready, kb: key_byte, sb: state_byte};
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle showing activity consumes one predicted observation.
    always @(negedge clk) begin
        if (!rst) begin
            obs_t o;
            o = sample();
            if (o.done || o.timeout || o.enable || o.busy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_activity: got %h expected no activity", o);
                end else begin
                    obs_t e;
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL stream_obs: got %h expected %h (done,timeout,enable,busy,in_ready,key,state)", o, e);
                    end
                end
            end
        end
    end

    // One transfer: r = WAIT cycle index on which core_ready is sampled high; r > T means never.
    task automatic send(input logic [127:0] k, input logic [127:0] d, input int r,
                        input bit noise_valid, input bit ready_in_feed, input bit release_rst);
        int nw;
        nw = (r > T) ? T : r;
        for (int i = 0; i < 16; i++)
            exp_q.push_back('{done: 1'b0, timeout: 1'b0, enable: 1'b1, busy: 1'b1, in_ready: 1'b0,
                              kb: byte_at(k, i), sb: byte_at(d, i)});
        for (int j = 0; j < nw; j++)
            exp_q.push_back('{done: 1'b0, timeout: 1'b0, enable: 1'b1, busy: 1'b1, in_ready: 1'b0,
                              kb: 8'h00, sb: 8'h00});
        exp_q.push_back('{done: (r <= T), timeout: (r > T), enable: 1'b0, busy: 1'b0, in_ready: 1'b1,
                          kb: 8'h00, sb: 8'h00});

        @(negedge clk);
        in_valid   = 1'b1;
        in_key     = k;
        in_data    = d;
        core_ready = 1'($urandom_range(0, 1));
        if (release_rst) rst = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            in_valid   = noise_valid;
            in_key     = rand128();
            in_data    = rand128();
            core_ready = ready_in_feed ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        for (int j = 1; j <= nw; j++) begin
            @(negedge clk);
            in_valid   = noise_valid;
            in_key     = rand128();
            in_data    = rand128();
            core_ready = (j == r);
            @(posedge clk);
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid   = 1'b0;
            core_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
    endtask

    // Watchdog bounding the whole run.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got no completion expected completion before time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [127:0] k0, d0, k1, d1;
        k0 = 128'h5468617473206D79204B756E67204675;
        d0 = 128'h54776F204F6E65204E696E652054776F;
        k1 = rand128();
        d1 = rand128();

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 128'({key_byte, state_byte, enable, done, timeout, busy, in_ready}), 128'd0);

        // Known vector, core_ready five cycles into WAIT, released straight out of reset.
        send(k0, d0, 5, 1'b0, 1'b0, 1'b1);
        // Timeout with core_ready never asserted, then core_ready on the expiring cycle.
        send(k1, d1, T + 3, 1'b0, 1'b0, 1'b0);
        send(rand128(), rand128(), T, 1'b0, 1'b0, 1'b0);
        // in_valid held with other data while busy; next pair lands on the done cycle.
        send(rand128(), rand128(), 2, 1'b1, 1'b0, 1'b0);
        send(rand128(), rand128(), 1, 1'b1, 1'b1, 1'b0);
        gap(2);

        // Reset in the middle of FEED, right after byte 7 is shown.
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{done: 1'b0, timeout: 1'b0, enable: 1'b1, busy: 1'b1, in_ready: 1'b0,
                              kb: byte_at(k1, i), sb: byte_at(d1, i)});
        @(negedge clk);
        in_valid = 1'b1;
        in_key   = k1;
        in_data  = d1;
        @(posedge clk);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 128'({key_byte, state_byte, enable, done, timeout, busy, in_ready}), 128'd0);
        check("abort_queue_drained", 128'(exp_q.size()), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_no_pulse", 128'({done, timeout}), 128'd0);
        send(k0, d0, 3, 1'b0, 1'b0, 1'b1);

        // Randomised traffic.
        for (int n = 0; n < 14; n++) begin
            send(rand128(), rand128(), $urandom_range(1, T + 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'b0);
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
        end

        gap(4);
        check("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_enc_feeder.md
AES_ENC_FEEDER -- requirements
Module: aes_enc_feeder

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles spent in WAIT for core_ready before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream offers a key/plaintext pair.
REQ-005 in_ready  output  1  feeder can accept a pair this cycle.
REQ-006 in_key  input  128  cipher key, byte 0 = bits [127:120].
REQ-007 in_data  input  128  plaintext block, byte 0 = bits [127:120].
REQ-008 key_byte  output  8  key byte to the encryption core.
REQ-009 state_byte  output  8  plaintext byte to the encryption core.
REQ-010 enable  output  1  core enable.
REQ-011 core_ready  input  1  ready output of the encryption core.
REQ-012 done  output  1  one-cycle pulse: core reported ready.
REQ-013 timeout  output  1  one-cycle pulse: WAIT expired without core_ready.
REQ-014 busy  output  1  high in FEED or WAIT.

Function
REQ-015 The FSM SHALL have states IDLE, FEED and WAIT.
REQ-016 in_ready SHALL equal (state==IDLE) and not rst.
REQ-017 Acceptance SHALL occur on a rising edge with in_valid and in_ready high; both 128-bit words are captured, state becomes FEED, byte counter is 0.
REQ-018 Outputs SHALL be registered: after acceptance edge N, key_byte/state_byte carry byte 0 and enable=1; after edge N+k (k=0..15) they carry byte k.
REQ-019 Bytes SHALL be sent MSB-first, byte k = bits [127-8k -: 8] of the captured words.
REQ-020 After edge N+15 the counter is 15; on edge N+16 the state SHALL become WAIT, key_byte/state_byte 0, enable held 1.
REQ-021 core_ready SHALL be ignored in IDLE and FEED.
REQ-022 In WAIT, core_ready sampled high SHALL, on that edge, return to IDLE, drive enable=0 and pulse done for one cycle.
REQ-023 In WAIT, a wait counter SHALL increment each cycle; when it reaches TIMEOUT_CYCLES without core_ready, the state SHALL return to IDLE, enable=0, and timeout pulses one cycle.
REQ-024 If core_ready is high on the cycle the wait counter reaches TIMEOUT_CYCLES, done SHALL win; timeout stays 0.
REQ-025 in_valid while busy SHALL be ignored and captured words unchanged.
REQ-026 A new pair SHALL be accepted in the same cycle done or timeout is high (back-to-back, no idle bubble).
REQ-027 busy SHALL be 1 exactly when state is FEED or WAIT.

Reset
REQ-028 rst high SHALL immediately force IDLE, counters 0, captured words 0, key_byte=0, state_byte=0, enable=0, done=0, timeout=0, busy=0, in_ready=0.
REQ-029 Reset mid-FEED or mid-WAIT SHALL abort the transfer with no done/timeout pulse; first acceptance possible on the first edge after rst deasserts.

Structure
REQ-030 Shared package aes_pkg SHALL hold AES_BLOCK_BITS=128, AES_BYTES=16 and the feeder state enum typedef.
REQ-031 One sub-module aes_byte_shifter (128-bit parallel-load, 8-bit MSB-first shift-out) SHALL be instantiated twice, key and data.

Verification
REQ-032 Reset then accept key 5468617473206D79204B756E67204675, data 54776F204F6E65204E696E652054776F -> bytes 54/54, 68/77, 61/6F ... 75/6F on 16 consecutive cycles, enable=1 throughout, then WAIT with bytes 00.
REQ-033 core_ready pulsed 5 cycles into WAIT -> enable falls and done=1 for exactly one cycle on that edge; in_ready=1 same cycle.
REQ-034 core_ready held low, TIMEOUT_CYCLES=8 -> timeout pulses after 8 WAIT cycles, done stays 0, returns IDLE.
REQ-035 in_valid held high with a second pair during FEED -> first stream unchanged; second pair accepted on the done cycle, byte 0 of second pair follows immediately.
REQ-036 rst asserted at FEED byte 7 -> all outputs 0 asynchronously, no done/timeout; next acceptance restarts at byte 0.
REQ-037 core_ready high during FEED -> ignored; all 16 bytes delivered and FSM enters WAIT.
